busca_instrucao: RTL and testbench
==================================

# busca_instrucao

Instruction fetch and issue unit for the single-cycle processor. It owns the program counter, fetches 16-bit instruction words from instruction memory over a req/ack handshake, and presents `OPcode` and `bit_menos_sig` to the control decoder for one execute cycle per instruction. It consumes the decoder's `jump`, `beq` and `halt` outputs plus the ALU equality flag to choose the next PC, and stops on halt or on a fetch timeout.

## Interface
- `LARGURA_PC`, 8: PC / instruction-memory address width.
- `LIMITE_ESPERA`, 15: maximum cycles waiting for `mem_ack` before fetch error.
- `clock` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `inicio` input 1: start pulse; accepted only in OCIOSO or PARADO.
- `mem_req` output 1: fetch request to instruction memory.
- `mem_endereco` output LARGURA_PC: fetch address, equals `pc`.
- `mem_ack` input 1: memory acknowledge; `mem_dado` valid in same cycle.
- `mem_dado` input 16: instruction word.
- `OPcode` output 3: `instrucao[15:13]`, to decoder.
- `bit_menos_sig` output 1: `instrucao[0]`, to decoder.
- `instrucao` output 16: registered instruction word.
- `instr_valida` output 1: high for exactly the one EXECUTA cycle.
- `jump`, `beq`, `halt` input 1 each: from the control decoder, sampled in EXECUTA.
- `igual` input 1: ALU equality flag, sampled in EXECUTA.
- `pc` output LARGURA_PC: current program counter.
- `parado` output 1: high in PARADO.
- `erro_busca` output 1: sticky; set on fetch timeout.

## Operation
- States: OCIOSO, BUSCA, EXECUTA, PARADO.
- OCIOSO: `inicio` -> `pc`=0, clear `erro_busca`, go to BUSCA.
- BUSCA: `mem_req`=1, `mem_endereco`=`pc` held stable. On `mem_ack`, register `mem_dado` into `instrucao`, clear the wait counter and go to EXECUTA.
- Wait counter: increments each BUSCA cycle without ack. If the counter reaches `LIMITE_ESPERA` with no ack, set `erro_busca`, drop `mem_req` and go to PARADO. An ack arriving in the same cycle the limit is reached wins.
- EXECUTA: `instr_valida`=1. The next PC is chosen by the first matching rule, in priority order:
  - `halt` -> PARADO, `pc` unchanged.
  - `jump` -> `pc` = `instrucao[LARGURA_PC-1:0]` (zero-extended if narrower than 13 bits), go to BUSCA.
  - `beq` & `igual` -> `pc` = `pc` + 1 + sign-extended `instrucao[7:0]`, go to BUSCA.
  - otherwise -> `pc` = `pc` + 1, go to BUSCA.
- All PC arithmetic is modulo 2^LARGURA_PC. Wrap-around is silent: incrementing from the max address gives 0, and negative offsets wrap.
- PARADO: `parado`=1, `mem_req`=0. `inicio` restarts from `pc`=0 and clears `erro_busca`. All other inputs are ignored.
- `inicio` outside OCIOSO and PARADO is ignored.
- `mem_ack` outside BUSCA is ignored.

## Timing
- Reset values, applied on the clock edge with `reset`=1 and overriding every other input:
  - state OCIOSO;
  - `pc`=0, `instrucao`=0;
  - `mem_req`=0, `instr_valida`=0, `parado`=0, `erro_busca`=0.
- Since `instrucao` resets to 0, `OPcode` and `bit_menos_sig` are 0 after reset.
- Reset mid-fetch drops `mem_req` the next cycle; a late ack is then ignored.
- `mem_req` is a registered state decode. It rises the cycle after `inicio` is sampled.
- With zero-wait memory (ack in the first BUSCA cycle), each instruction takes 2 cycles: BUSCA, then EXECUTA.
- `OPcode`, `bit_menos_sig` and `instrucao` stay stable from EXECUTA until the next ack.
- `pc` updates on the edge that leaves EXECUTA.

## Structure
- Shared package `pacote_processador` holds:
  - opcode constants (ADD=0, ADDI=1, BEQ=2, LW=3, SW=4, J=5, MUL=6);
  - instruction field positions (opcode [15:13], LSB [0], offset [7:0]);
  - the state encoding for this block.
- Sub-module `contador_programa`: combinational next-PC selection plus the registered PC. Inputs are `halt`/`jump`/`beq`/`igual`, the instruction fields and a load enable.
- The FSM and wait counter live in `busca_instrucao`.

## Test plan
- Reset, then `inicio`; memory acks immediately with 0x0000 (add), then 0x0001 (halt). Required response:
  - `pc` goes 0, 1;
  - `instr_valida` pulses twice, two cycles apart;
  - `parado`=1 with `pc`=1.
- Jump: at `pc`=3, `mem_dado`=0xA005 and `jump`=1. Required response: next `mem_endereco`=5.
- Branch at `pc`=10 with `instrucao[7:0]`=0xFC (-4), `beq`=1:
  - with `igual`=1 -> next `pc`=7;
  - with `igual`=0 -> next `pc`=11.
- Wrap-around (LARGURA_PC=8):
  - `pc`=255 with a plain instruction -> next `pc`=0;
  - `pc`=1 with `beq`, `igual`=1 and offset 0x80 -> next `pc`=130 (0x82).
- Timeout: memory never acks. Required response: `mem_req` stays high for 15 cycles, then `erro_busca`=1 and `parado`=1. A later `inicio` clears the error and fetches from 0.
- Reset asserted mid-BUSCA with a delayed ack. Required response: outputs return to reset values the next cycle, and the late ack leaves `instrucao`=0.

Source files
------------

// File: rtl/busca_instrucao_pkg.sv
// pacote_processador: constants shared by the processor blocks.
//   - opcode encodings seen by the control decoder
//   - instruction field positions
//   - state encoding of the instruction fetch unit (busca_instrucao)
package pacote_processador;

  // Opcode encodings (instrucao[15:13])
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_BEQ  = 3'd2;
  localparam logic [2:0] OP_LW   = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_J    = 3'd5;
  localparam logic [2:0] OP_MUL  = 3'd6;

  // Instruction field positions
  localparam int unsigned LARGURA_INSTR   = 16;
  localparam int unsigned CAMPO_OP_MSB    = 15;
  localparam int unsigned CAMPO_OP_LSB    = 13;
  localparam int unsigned CAMPO_LSB       = 0;
  localparam int unsigned CAMPO_DESL_MSB  = 7;
  localparam int unsigned CAMPO_DESL_LSB  = 0;
  localparam int unsigned CAMPO_SALTO_MSB = 12;

  // Fetch unit states
  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    BUSCA   = 2'd1,
    EXECUTA = 2'd2,
    PARADO  = 2'd3
  } estado_busca_t;

endpackage

// File: rtl/busca_instrucao_if.sv
// Instruction-memory fetch bus (req/ack handshake).
//   mem_req      : fetch request, driven by the fetch unit
//   mem_endereco : fetch address, driven by the fetch unit
//   mem_ack      : acknowledge from memory; mem_dado valid in the same cycle
//   mem_dado     : 16-bit instruction word from memory
// Modports: master = fetch unit, slave = instruction memory.
interface busca_instrucao_if #(
  parameter int unsigned LARGURA_PC = 8
);
  logic                  mem_req;
  logic [LARGURA_PC-1:0] mem_endereco;
  logic                  mem_ack;
  logic [15:0]           mem_dado;

  modport master (
    output mem_req,
    output mem_endereco,
    input  mem_ack,
    input  mem_dado
  );

  modport slave (
    input  mem_req,
    input  mem_endereco,
    output mem_ack,
    output mem_dado
  );
endinterface

// File: rtl/busca_instrucao_contador_programa.sv
// contador_programa: registered program counter with next-PC selection.
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   limpar        : force PC to 0 (program (re)start), highest priority
//   carregar      : apply next-PC rule (asserted during the execute cycle)
//   halt/jump/beq : decoder outputs; igual = ALU equality flag
//   campo_salto   : instrucao[12:0], absolute jump target field
//   deslocamento  : instrucao[7:0], signed branch offset
//   pc            : current program counter
// All arithmetic is modulo 2^LARGURA_PC.
module contador_programa #(
  parameter int unsigned LARGURA_PC = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  limpar,
  input  logic                  carregar,
  input  logic                  halt,
  input  logic                  jump,
  input  logic                  beq,
  input  logic                  igual,
  input  logic [12:0]           campo_salto,
  input  logic [7:0]            deslocamento,
  output logic [LARGURA_PC-1:0] pc
);

  logic [LARGURA_PC-1:0] pc_q;
  logic [LARGURA_PC-1:0] pc_d;
  logic [LARGURA_PC-1:0] pc_mais_um;
  logic [LARGURA_PC-1:0] alvo_salto;
  logic [LARGURA_PC-1:0] desl_ext;

  // Size casts: the jump field is zero-extended (or truncated to the PC
  // width); the signed offset is sign-extended before the modular add.
  assign pc_mais_um = pc_q + LARGURA_PC'(1);
  assign alvo_salto = LARGURA_PC'(campo_salto);
  assign desl_ext   = LARGURA_PC'($signed(deslocamento));

  always_comb begin
    pc_d = pc_q;
    if (limpar) begin
      pc_d = '0;
    end else if (carregar) begin
      if (halt) begin
        pc_d = pc_q;
      end else if (jump) begin
        pc_d = alvo_salto;
      end else if (beq && igual) begin
        pc_d = pc_mais_um + desl_ext;
      end else begin
        pc_d = pc_mais_um;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/busca_instrucao.sv
// busca_instrucao: instruction fetch and issue unit.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   inicio              : start pulse, honoured only in OCIOSO / PARADO
//   mem (master)        : instruction-memory req/ack fetch bus
//   OPcode, bit_menos_sig, instrucao : registered instruction and fields
//   instr_valida        : high for the single execute cycle
//   jump, beq, halt     : decoder outputs, sampled in EXECUTA
//   igual               : ALU equality flag, sampled in EXECUTA
//   pc                  : program counter (also the fetch address)
//   parado              : high while stopped
//   erro_busca          : sticky fetch-timeout flag, cleared by inicio
module busca_instrucao
  import pacote_processador::*;
#(
  parameter int unsigned LARGURA_PC    = 8,
  parameter int unsigned LIMITE_ESPERA = 15
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   inicio,
  busca_instrucao_if.master      mem,
  output logic [2:0]             OPcode,
  output logic                   bit_menos_sig,
  output logic [15:0]            instrucao,
  output logic                   instr_valida,
  input  logic                   jump,
  input  logic                   beq,
  input  logic                   halt,
  input  logic                   igual,
  output logic [LARGURA_PC-1:0]  pc,
  output logic                   parado,
  output logic                   erro_busca
);

  localparam int unsigned ESPERA_W = $clog2(LIMITE_ESPERA + 1);
  localparam logic [ESPERA_W-1:0] LIMITE_CONT = ESPERA_W'(LIMITE_ESPERA);

  estado_busca_t         estado_q, estado_d;
  logic [ESPERA_W-1:0]   espera_q, espera_d;
  logic [ESPERA_W-1:0]   espera_inc;
  logic [15:0]           instrucao_q, instrucao_d;
  logic                  mem_req_q, mem_req_d;
  logic                  instr_valida_q, instr_valida_d;
  logic                  parado_q, parado_d;
  logic                  erro_busca_q, erro_busca_d;
  logic                  limpar_pc;
  logic                  carregar_pc;

  assign espera_inc = espera_q + 1'b1;

  always_comb begin
    estado_d     = estado_q;
    espera_d     = espera_q;
    instrucao_d  = instrucao_q;
    erro_busca_d = erro_busca_q;
    limpar_pc    = 1'b0;
    carregar_pc  = 1'b0;

    case (estado_q)
      OCIOSO, PARADO: begin
        if (inicio) begin
          estado_d     = BUSCA;
          espera_d     = '0;
          erro_busca_d = 1'b0;
          limpar_pc    = 1'b1;
        end
      end
      BUSCA: begin
        // An ack in the cycle the limit is reached still wins.
        if (mem.mem_ack) begin
          instrucao_d = mem.mem_dado;
          espera_d    = '0;
          estado_d    = EXECUTA;
        end else if (espera_inc == LIMITE_CONT) begin
          espera_d     = '0;
          erro_busca_d = 1'b1;
          estado_d     = PARADO;
        end else begin
          espera_d = espera_inc;
        end
      end
      EXECUTA: begin
        carregar_pc = 1'b1;
        estado_d    = halt ? PARADO : BUSCA;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase

    // Outputs are decodes of the next state, so they are registered and
    // line up with the state they describe.
    mem_req_d      = (estado_d == BUSCA);
    instr_valida_d = (estado_d == EXECUTA);
    parado_d       = (estado_d == PARADO);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q       <= OCIOSO;
      espera_q       <= '0;
      instrucao_q    <= '0;
      mem_req_q      <= 1'b0;
      instr_valida_q <= 1'b0;
      parado_q       <= 1'b0;
      erro_busca_q   <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      espera_q       <= espera_d;
      instrucao_q    <= instrucao_d;
      mem_req_q      <= mem_req_d;
      instr_valida_q <= instr_valida_d;
      parado_q       <= parado_d;
      erro_busca_q   <= erro_busca_d;
    end
  end

  contador_programa #(
    .LARGURA_PC (LARGURA_PC)
  ) u_contador_programa (
    .clock        (clock),
    .reset        (reset),
    .limpar       (limpar_pc),
    .carregar     (carregar_pc),
    .halt         (halt),
    .jump         (jump),
    .beq          (beq),
    .igual        (igual),
    .campo_salto  (instrucao_q[CAMPO_SALTO_MSB:0]),
    .deslocamento (instrucao_q[CAMPO_DESL_MSB:CAMPO_DESL_LSB]),
    .pc           (pc)
  );

  assign mem.mem_req      = mem_req_q;
  assign mem.mem_endereco = pc;

  assign instrucao     = instrucao_q;
  assign OPcode        = instrucao_q[CAMPO_OP_MSB:CAMPO_OP_LSB];
  assign bit_menos_sig = instrucao_q[CAMPO_LSB];
  assign instr_valida  = instr_valida_q;
  assign parado        = parado_q;
  assign erro_busca    = erro_busca_q;

endmodule

// File: tb/tb_busca_instrucao.sv
module tb_busca_instrucao;

  logic        clock = 1'b0;
  logic        reset;
  logic        inicio;
  logic        jump, beq, halt, igual;
  logic [2:0]  OPcode;
  logic        bit_menos_sig;
  logic [15:0] instrucao;
  logic        instr_valida;
  logic [7:0]  pc;
  logic        parado;
  logic        erro_busca;

  busca_instrucao_if #(.LARGURA_PC(8)) bus ();

  busca_instrucao #(
    .LARGURA_PC    (8),
    .LIMITE_ESPERA (15)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .inicio        (inicio),
    .mem           (bus),
    .OPcode        (OPcode),
    .bit_menos_sig (bit_menos_sig),
    .instrucao     (instrucao),
    .instr_valida  (instr_valida),
    .jump          (jump),
    .beq           (beq),
    .halt          (halt),
    .igual         (igual),
    .pc            (pc),
    .parado        (parado),
    .erro_busca    (erro_busca)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] word;
    int unsigned gap;
  } esperado_t;

  esperado_t   fila[$];
  int          tests = 0;
  int          fails = 0;
  int unsigned ciclo = 0;
  int unsigned ultimo_valido = 0;

  always @(posedge clock) ciclo <= ciclo + 1;

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] req);
    tests++;
    if (atual !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nome, atual, req);
    end
  endtask

  // Monitor: every execute cycle is matched against the scoreboard.
  initial begin
    forever begin
      esperado_t e;
      @(posedge clock);
      #1;
      if (instr_valida === 1'b1) begin
        if (fila.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: instr_valida=1 at pc=0x%0h, required no execute", pc);
        end else begin
          e = fila.pop_front();
          check("exec_pc", pc, e.pc);
          check("exec_instr", instrucao, e.word);
          check("exec_opcode", OPcode, e.word[15:13]);
          check("exec_lsb", bit_menos_sig, e.word[0]);
          if (e.gap != 0) check("valid_spacing", ciclo - ultimo_valido, e.gap);
        end
        ultimo_valido = ciclo;
      end
    end
  end

  task automatic pulse_inicio();
    @(negedge clock);
    inicio = 1'b1;
    @(negedge clock);
    inicio = 1'b0;
  endtask

  // Issue one instruction: wait for the fetch, ack after 'atraso' idle
  // BUSCA cycles, then drive the decoder outputs during EXECUTA.
  // Called and returns on a negedge.
  task automatic exec_instr(input logic [15:0] word, input logic j, input logic b,
                            input logic h, input logic ig, input logic [7:0] pc_exp,
                            input int unsigned atraso, input int unsigned gap);
    esperado_t   e;
    int unsigned n;
    n = 0;
    e.pc = pc_exp;
    e.word = word;
    e.gap = gap;
    fila.push_back(e);
    while (bus.mem_req !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (bus.mem_req !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL fetch_wait: mem_req=%b after %0d cycles, required 1", bus.mem_req, n);
      void'(fila.pop_back());
      return;
    end
    check("fetch_addr", bus.mem_endereco, pc_exp);
    repeat (atraso) @(negedge clock);
    bus.mem_ack  = 1'b1;
    bus.mem_dado = word;
    @(negedge clock);
    bus.mem_ack  = 1'b0;
    bus.mem_dado = 16'h0000;
    jump  = j;
    beq   = b;
    halt  = h;
    igual = ig;
    @(negedge clock);
    jump  = 1'b0;
    beq   = 1'b0;
    halt  = 1'b0;
    igual = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    inicio = 1'b0;
    jump = 1'b0;
    beq = 1'b0;
    halt = 1'b0;
    igual = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_dado = 16'h0000;

    // Reset values
    repeat (2) @(negedge clock);
    check("rst_pc", pc, 8'h00);
    check("rst_instr", instrucao, 16'h0000);
    check("rst_opcode", OPcode, 3'd0);
    check("rst_lsb", bit_menos_sig, 1'b0);
    check("rst_req", bus.mem_req, 1'b0);
    check("rst_valid", instr_valida, 1'b0);
    check("rst_parado", parado, 1'b0);
    check("rst_erro", erro_busca, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_req", bus.mem_req, 1'b0);

    // Add then halt with zero-wait memory
    pulse_inicio();
    exec_instr(16'h0000, 0, 0, 0, 0, 8'd0, 0, 0);
    exec_instr(16'h0001, 0, 0, 1, 0, 8'd1, 0, 2);
    check("halt_parado", parado, 1'b1);
    check("halt_pc", pc, 8'd1);
    check("halt_req", bus.mem_req, 1'b0);

    // Jump, branches, wrap-around
    pulse_inicio();
    exec_instr(16'h0000, 0, 0, 0, 0, 8'd0, 0, 0);
    exec_instr(16'h2001, 0, 0, 0, 0, 8'd1, 0, 2);
    exec_instr(16'h0000, 0, 0, 0, 0, 8'd2, 0, 2);
    exec_instr(16'hA005, 1, 0, 0, 0, 8'd3, 0, 2);
    exec_instr(16'hA00A, 1, 0, 0, 0, 8'd5, 0, 2);
    exec_instr(16'h40FC, 0, 1, 0, 1, 8'd10, 0, 2);
    exec_instr(16'hA00A, 1, 0, 0, 0, 8'd7, 0, 2);
    exec_instr(16'h40FC, 0, 1, 0, 0, 8'd10, 0, 2);
    exec_instr(16'hA0FF, 1, 0, 0, 0, 8'd11, 0, 2);
    exec_instr(16'h0000, 0, 0, 0, 0, 8'd255, 0, 2);
    exec_instr(16'h0000, 0, 0, 0, 0, 8'd0, 0, 2);
    exec_instr(16'h4080, 0, 1, 0, 1, 8'd1, 0, 2);
    exec_instr(16'h0001, 0, 0, 1, 0, 8'd130, 0, 2);
    check("wrap_parado", parado, 1'b1);
    check("wrap_pc", pc, 8'd130);

    // Timeout: memory never acks
    pulse_inicio();
    n = 0;
    while (bus.mem_req === 1'b1 && n < 40) begin
      n++;
      @(negedge clock);
    end
    check("timeout_req_cycles", n, 15);
    check("timeout_erro", erro_busca, 1'b1);
    check("timeout_parado", parado, 1'b1);

    // Restart clears the error; ack on the last allowed cycle is accepted
    pulse_inicio();
    check("restart_erro", erro_busca, 1'b0);
    check("restart_pc", pc, 8'd0);
    exec_instr(16'h2003, 0, 0, 0, 0, 8'd0, 14, 0);
    exec_instr(16'h0001, 0, 0, 1, 0, 8'd1, 0, 2);
    check("limit_ack_erro", erro_busca, 1'b0);
    check("limit_ack_parado", parado, 1'b1);

    // Reset mid-BUSCA with a late ack
    pulse_inicio();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_req", bus.mem_req, 1'b0);
    check("midrst_pc", pc, 8'd0);
    check("midrst_instr", instrucao, 16'h0000);
    check("midrst_parado", parado, 1'b0);
    reset = 1'b0;
    bus.mem_ack = 1'b1;
    bus.mem_dado = 16'hBEEF;
    @(negedge clock);
    bus.mem_ack = 1'b0;
    bus.mem_dado = 16'h0000;
    check("late_ack_instr", instrucao, 16'h0000);
    check("late_ack_req", bus.mem_req, 1'b0);
    check("late_ack_valid", instr_valida, 1'b0);

    repeat (3) @(negedge clock);
    check("scoreboard_drain", fila.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
